// File: rtl/intersection_ctrl_if.sv
// Signal bundle between the intersection controller and its environment:
// sensor/button requests in, lamp drives and 7-segment phase/timer out.
interface intersection_ctrl_if #(
   parameter int unsigned CW = 4
);
   logic          req_b;
   logic          ped_req;
   logic          a_red;
   logic          a_yellow;
   logic          a_green;
   logic          b_red;
   logic          b_yellow;
   logic          b_green;
   logic          walk;
   logic          ped_pending;
   logic [3:0]    phase;
   logic [CW-1:0] remaining;

   modport master (
      output req_b, ped_req,
      input  a_red, a_yellow, a_green, b_red, b_yellow, b_green,
      input  walk, ped_pending, phase, remaining
   );

   modport slave (
      input  req_b, ped_req,
      output a_red, a_yellow, a_green, b_red, b_yellow, b_green,
      output walk, ped_pending, phase, remaining
   );
endinterface

// File: rtl/intersection_ctrl.sv
// Two-approach traffic-light sequencer: A green by default, B on sensor demand,
// latched pedestrian walk phase; outputs decode from registered state only.
module intersection_ctrl #(
   parameter int unsigned CW           = 4,
   parameter int unsigned T_STARTUP    = 6,
   parameter int unsigned T_ALL_RED    = 2,
   parameter int unsigned T_RED_YELLOW = 2,
   parameter int unsigned T_MIN_GREEN  = 6,
   parameter int unsigned T_MAX_GREEN  = 12,
   parameter int unsigned T_YELLOW     = 3,
   parameter int unsigned T_WALK       = 5
) (
   input logic               clk,
   input logic               resetn,
   intersection_ctrl_if.slave bus
);
   typedef enum logic [3:0] {
      StStartup = 4'd0, StAllRed1 = 4'd1, StARy    = 4'd2, StAGreen = 4'd3,
      StAYellow = 4'd4, StAllRed2 = 4'd5, StWalk   = 4'd6, StBRy    = 4'd7,
      StBGreen  = 4'd8, StBYellow = 4'd9
   } state_e;

   // Last count value of each phase; a phase of length T exits when cnt hits T-1.
   localparam logic [CW-1:0] StartupEnd  = CW'(T_STARTUP - 1);
   localparam logic [CW-1:0] AllRedEnd   = CW'(T_ALL_RED - 1);
   localparam logic [CW-1:0] RedYelEnd   = CW'(T_RED_YELLOW - 1);
   localparam logic [CW-1:0] MinGreenEnd = CW'(T_MIN_GREEN - 1);
   localparam logic [CW-1:0] MaxGreenEnd = CW'(T_MAX_GREEN - 1);
   localparam logic [CW-1:0] YellowEnd   = CW'(T_YELLOW - 1);
   localparam logic [CW-1:0] WalkEnd     = CW'(T_WALK - 1);
   localparam logic [CW-1:0] CntMax      = '1;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          blink_q, blink_d;
   logic          ped_q, ped_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StStartup;
         cnt_q   <= '0;
         blink_q <= 1'b0;
         ped_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         blink_q <= blink_d;
         ped_q   <= ped_d;
      end
   end

   always_comb begin
      state_d = state_q;
      blink_d = 1'b0;
      ped_d   = ped_q;
      case (state_q)
         StStartup: begin
            blink_d = ~blink_q;
            if (cnt_q == StartupEnd) state_d = StAllRed1;
         end
         StAllRed1: if (cnt_q == AllRedEnd) state_d = StARy;
         StARy:     if (cnt_q == RedYelEnd) state_d = StAGreen;
         StAGreen:  if (cnt_q >= MinGreenEnd && (bus.req_b || ped_q)) state_d = StAYellow;
         StAYellow: if (cnt_q == YellowEnd) state_d = StAllRed2;
         StAllRed2: begin
            if (cnt_q == AllRedEnd) begin
               if (ped_q)          state_d = StWalk;
               else if (bus.req_b) state_d = StBRy;
               else                state_d = StARy;
            end
         end
         StWalk:    if (cnt_q == WalkEnd) state_d = bus.req_b ? StBRy : StARy;
         StBRy:     if (cnt_q == RedYelEnd) state_d = StBGreen;
         StBGreen: begin
            if (cnt_q == MaxGreenEnd || (cnt_q >= MinGreenEnd && (!bus.req_b || ped_q))) begin
               state_d = StBYellow;
            end
         end
         StBYellow: if (cnt_q == YellowEnd) state_d = StAllRed1;
         default:   state_d = StStartup;
      endcase

      if (state_d != state_q)                         cnt_d = '0;
      else if (state_q == StAGreen && cnt_q == CntMax) cnt_d = cnt_q;
      else                                            cnt_d = cnt_q + CW'(1);

      // Entering WALK serves the request, so the clear beats a same-cycle press.
      if (state_d == StWalk && state_q != StWalk)                     ped_d = 1'b0;
      else if (bus.ped_req && state_q != StWalk && state_d != StWalk) ped_d = 1'b1;
   end

   always_comb begin
      bus.a_red       = 1'b0;
      bus.a_yellow    = 1'b0;
      bus.a_green     = 1'b0;
      bus.b_red       = 1'b0;
      bus.b_yellow    = 1'b0;
      bus.b_green     = 1'b0;
      bus.walk        = 1'b0;
      bus.remaining   = '0;
      bus.phase       = state_q;
      bus.ped_pending = ped_q;
      case (state_q)
         StStartup: begin
            bus.a_yellow  = blink_q;
            bus.b_yellow  = blink_q;
            bus.remaining = StartupEnd - cnt_q;
         end
         StAllRed1, StAllRed2: begin
            bus.a_red     = 1'b1;
            bus.b_red     = 1'b1;
            bus.remaining = AllRedEnd - cnt_q;
         end
         StARy: begin
            bus.a_red     = 1'b1;
            bus.a_yellow  = 1'b1;
            bus.b_red     = 1'b1;
            bus.remaining = RedYelEnd - cnt_q;
         end
         StAGreen: begin
            bus.a_green   = 1'b1;
            bus.b_red     = 1'b1;
            bus.remaining = (cnt_q < MinGreenEnd) ? MinGreenEnd - cnt_q : '0;
         end
         StAYellow: begin
            bus.a_yellow  = 1'b1;
            bus.b_red     = 1'b1;
            bus.remaining = YellowEnd - cnt_q;
         end
         StWalk: begin
            bus.a_red     = 1'b1;
            bus.b_red     = 1'b1;
            bus.walk      = 1'b1;
            bus.remaining = WalkEnd - cnt_q;
         end
         StBRy: begin
            bus.a_red     = 1'b1;
            bus.b_red     = 1'b1;
            bus.b_yellow  = 1'b1;
            bus.remaining = RedYelEnd - cnt_q;
         end
         StBGreen: begin
            bus.a_red     = 1'b1;
            bus.b_green   = 1'b1;
            bus.remaining = MaxGreenEnd - cnt_q;
         end
         StBYellow: begin
            bus.a_red     = 1'b1;
            bus.b_yellow  = 1'b1;
            bus.remaining = YellowEnd - cnt_q;
         end
         default: ;
      endcase
   end
endmodule

// File: doc/intersection_ctrl.md
Name: intersection_ctrl

Overview:
Two-approach intersection controller for the TinyTapeout traffic-light design. Main street A is green by default; side street B gets green on a vehicle sensor request; a latched pedestrian request inserts an all-vehicles-red walk phase. The block sequences both signal heads through amber, all-red clearance and red-yellow phases, and exports phase and remaining-time for a 7-segment decoder.

Parameters:
CW, 4, width of phase cycle counter and remaining output
T_STARTUP, 6, cycles of startup yellow blink
T_ALL_RED, 2, cycles of all-red clearance
T_RED_YELLOW, 2, cycles of red+yellow before green
T_MIN_GREEN, 6, minimum green cycles (A and B)
T_MAX_GREEN, 12, maximum green cycles for B
T_YELLOW, 3, cycles of yellow
T_WALK, 5, cycles of pedestrian walk

Ports:
clk  in  1  clock, one tick = one time unit
resetn  in  1  asynchronous active-low reset
req_b  in  1  side-street vehicle sensor, level
ped_req  in  1  pedestrian button, sampled every cycle
a_red, a_yellow, a_green  out  1 each  approach A head
b_red, b_yellow, b_green  out  1 each  approach B head
walk  out  1  pedestrian walk lamp
ped_pending  out  1  pedestrian request latched, not yet served
phase  out  4  current state code
remaining  out  CW  cycles left in current timed phase

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, resetn).
- Registers: state, cnt (CW bits), blink, ped_pending. Lights, walk, remaining are decoded combinationally from registered state only; no input-to-output combinational path.
- State codes: STARTUP=0, ALL_RED_1=1, A_RY=2, A_GREEN=3, A_YELLOW=4, ALL_RED_2=5, WALK=6, B_RY=7, B_GREEN=8, B_YELLOW=9. Codes 10-15 go to STARTUP with cnt=0 on the next edge.
- Reset values: state=STARTUP, cnt=0, blink=0, ped_pending=0. So all lights=0, walk=0, phase=0, remaining=T_STARTUP-1.
- cnt clears to 0 on every state change, else increments. In A_GREEN it saturates at 2^CW-1.
- A timed state with duration T lasts exactly T cycles and exits on the edge where cnt==T-1.
- STARTUP (T_STARTUP): blink toggles every cycle; a_yellow=b_yellow=blink; all other lamps off. blink is forced to 0 in every other state. Exits to ALL_RED_1.
- ALL_RED_1 (T_ALL_RED): a_red=b_red=1. Exits to A_RY.
- A_RY (T_RED_YELLOW): a_red=a_yellow=1, b_red=1. Exits to A_GREEN.
- A_GREEN: a_green=1, b_red=1. Untimed.
  - Exits to A_YELLOW when cnt>=T_MIN_GREEN-1 and (req_b or ped_pending).
  - With no request, it holds indefinitely.
- A_YELLOW (T_YELLOW): a_yellow=1, b_red=1. Exits to ALL_RED_2.
- ALL_RED_2 (T_ALL_RED): a_red=b_red=1. At exit, priority is: ped_pending goes to WALK; else req_b goes to B_RY; else A_RY.
- WALK (T_WALK): a_red=b_red=walk=1. At exit: req_b goes to B_RY, else A_RY.
- B_RY (T_RED_YELLOW): b_red=b_yellow=1, a_red=1. Exits to B_GREEN.
- B_GREEN: b_green=1, a_red=1. Exits to B_YELLOW when either:
  - cnt==T_MAX_GREEN-1, or
  - cnt>=T_MIN_GREEN-1 and (!req_b or ped_pending).
- B_YELLOW (T_YELLOW): b_yellow=1, a_red=1. Exits to ALL_RED_1; a pending pedestrian is served after the next A green.
- ped_pending:
  - Set on any edge with ped_req=1 while state!=WALK and next state!=WALK.
  - Cleared on the edge entering WALK; that clear wins over a simultaneous ped_req.
  - ped_req during WALK is ignored.
- remaining:
  - Timed states: T-1-cnt.
  - A_GREEN: T_MIN_GREEN-1-cnt while cnt<T_MIN_GREEN-1, else 0.
  - B_GREEN: T_MAX_GREEN-1-cnt.
- Invariant: at most one of a_green/b_green/walk is high; any green or walk implies the other head is red.
- resetn low mid-phase: immediate return to reset values; ped_pending is lost.

Test Plan:
- Release reset with req_b=0, ped_req=0 → phase 0 for 6 cycles with yellows 0,1,0,1,0,1; then phase 1 for 2 cycles, phase 2 for 2, then phase 3; holds phase 3 for 50 further cycles, remaining=0 after cnt 5.
- In A_GREEN at cnt=2, hold req_b=1 → A green for exactly 6 cycles, yellow 3, all-red 2, B_RY 2. B_GREEN lasts 12 cycles (remaining 11→0), then B_YELLOW 3, ALL_RED_1 2, A_RY.
- req_b pulsed high for 4 cycles at B_GREEN entry → B_GREEN lasts exactly 6 cycles.
- One-cycle ped_req in A_GREEN with req_b=0 → ped_pending=1. Sequence A_YELLOW, ALL_RED_2, then WALK for 5 cycles with walk=1 and ped_pending cleared on WALK entry, then A_RY.
- ped_req and req_b both asserted in A_GREEN → WALK precedes B_RY. A second ped_req during WALK leaves ped_pending=0.
- Assert resetn=0 asynchronously mid B_GREEN → all lamps 0, phase 0, ped_pending 0 before the next clk edge. Every cycle of all tests checks the mutual-exclusion invariant.
